// File: rtl/vram_read_arbiter_pkg.sv
// vram_pkg: shared definitions for the VRAM read arbiter.
//   arb_state_t   - arbiter state (RUN, DRAIN, PAUSED)
//   TAG_DEPTH     - tag delay-line depth for the default memory latency
//   tag_depth()   - tag delay-line depth for an arbitrary memory latency
//   rr_next_grant - round-robin search; returns the winning index, or
//                   num_req when no requester is valid
package vram_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } arb_state_t;

    localparam int unsigned DEFAULT_MEM_LATENCY = 2;
    localparam int unsigned TAG_DEPTH           = DEFAULT_MEM_LATENCY + 1;

    // One extra stage covers the mem_en/mem_addr output register.
    function automatic int unsigned tag_depth(input int unsigned mem_latency);
        return mem_latency + 1;
    endfunction

    // Search starts one past the last winner and wraps; supports up to 32 requesters.
    function automatic int unsigned rr_next_grant(input logic [31:0] valid,
                                                  input int unsigned last_grant,
                                                  input int unsigned num_req);
        int unsigned pick;
        int unsigned idx;
        pick = num_req;
        for (int unsigned k = 1; k <= num_req; k++) begin
            idx = (last_grant + k) % num_req;
            if (pick == num_req && valid[idx[4:0]]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/vram_read_arbiter_latency.sv
// latency: generic shift-register delay line.
//   clk     - rising-edge clock
//   rst     - synchronous, active-high reset; clears every stage
//   sample  - value entering the line
//   delayed - sample as it was LENGTH cycles earlier
module latency #(
    parameter int unsigned LENGTH = 1,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] stage [LENGTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LENGTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= sample;
            for (int unsigned i = 1; i < LENGTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign delayed = stage[LENGTH-1];

endmodule

// File: rtl/vram_read_arbiter.sv
// vram_read_arbiter: round-robin sharing of one fixed-latency, non-stallable
// memory read port among NUM_REQ requesters, with a pause/drain handshake.
//   clk, rst             - clock; synchronous active-low reset
//   req_valid/req_addr   - per-requester read requests (packed addresses)
//   req_ready            - one-hot combinational grant
//   mem_en/mem_addr      - registered memory read port
//   mem_rdata            - memory data, MEM_LATENCY cycles after mem_en
//   rsp_valid/rsp_data   - one-hot response strobe and returned data
//   pause_req/pause_ack  - quiesce request and acknowledge (drained)
//   busy                 - at least one read in flight
module vram_read_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          mem_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          pause_req,
    output logic                          pause_ack,
    output logic                          busy
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_W   = $clog2(MEM_LATENCY + 2);
    localparam int unsigned TAG_LEN = tag_depth(MEM_LATENCY);

    arb_state_t             state;
    logic [IDX_W-1:0]       last_grant;
    logic [CNT_W-1:0]       inflight;
    logic [CNT_W-1:0]       inflight_next;
    logic [31:0]            valid_wide;
    int unsigned            pick;
    logic [IDX_W-1:0]       pick_idx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   transfer;
    logic                   rsp_any;

    // Grants are also masked while reset is held, so nothing is offered
    // to a requester before the arbiter is out of reset.
    always_comb begin
        valid_wide               = '0;
        valid_wide[NUM_REQ-1:0]  = req_valid;
        pick                     = rr_next_grant(valid_wide, 32'(last_grant), NUM_REQ);
        pick_idx                 = pick[IDX_W-1:0];
        sel_addr                 = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
        req_ready                = '0;
        transfer                 = 1'b0;
        if (rst && state == RUN && pick < NUM_REQ) begin
            req_ready[pick_idx] = 1'b1;
            transfer            = 1'b1;
        end
    end

    assign rsp_any = |rsp_valid;

    always_comb begin
        inflight_next = inflight;
        if (transfer && !rsp_any) begin
            inflight_next = inflight + CNT_W'(1);
        end else if (!transfer && rsp_any) begin
            inflight_next = inflight - CNT_W'(1);
        end
    end

    // DRAIN completes on the next count, so pause_ack is visible the
    // cycle right after the final response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            last_grant <= IDX_W'(NUM_REQ - 1);
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            inflight   <= '0;
            pause_ack  <= 1'b0;
        end else begin
            mem_en   <= transfer;
            inflight <= inflight_next;
            if (transfer) begin
                mem_addr   <= sel_addr;
                last_grant <= pick_idx;
            end
            case (state)
                RUN: begin
                    if (pause_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pause_req) begin
                        state <= RUN;
                    end else if (inflight_next == '0) begin
                        state     <= PAUSED;
                        pause_ack <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (!pause_req) begin
                        state     <= RUN;
                        pause_ack <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    pause_ack <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (inflight != '0);
    assign rsp_data = mem_rdata;

    // Grant vector travels alongside the read so the data is steered back
    // to the requester that issued it.
    latency #(
        .LENGTH (TAG_LEN),
        .WIDTH  (NUM_REQ)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (~rst),
        .sample  (req_ready),
        .delayed (rsp_valid)
    );

endmodule

// File: tb/tb_vram_read_arbiter.sv
// tb_vram_read_arbiter: randomized self-checking bench for vram_read_arbiter.
// A behavioural model (queue of outstanding reads, round-robin pointer,
// pause mode) predicts every output each cycle.
module tb_vram_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 17;
    localparam int DW = 8;
    localparam int L  = 2;

    localparam int MODE_RUN    = 0;
    localparam int MODE_DRAIN  = 1;
    localparam int MODE_PAUSED = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_ready;
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              pause_req;
    logic              pause_ack;
    logic              busy;

    always #5 clk = ~clk;

    vram_read_arbiter #(
        .NUM_REQ     (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_LATENCY (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .pause_req (pause_req),
        .pause_ack (pause_ack),
        .busy      (busy)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5A;
    endfunction

    // Memory: data for an address read in cycle c appears in cycle c+L.
    logic [DW-1:0] mem_pipe [L];
    always @(posedge clk) begin
        mem_pipe[0] <= mem_en ? mem_word(mem_addr) : 8'h00;
        for (int i = 1; i < L; i++) begin
            mem_pipe[i] <= mem_pipe[i-1];
        end
    end
    assign mem_rdata = mem_pipe[L-1];

    typedef struct {
        int            due;
        int            idx;
        logic [AW-1:0] addr;
    } pend_t;

    pend_t         q[$];
    int            m_mode;
    int            m_last;
    logic          m_mem_en;
    logic [AW-1:0] m_mem_addr;
    logic          m_ack;
    int            cyc;
    int            checks;
    int            failures;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode     = MODE_RUN;
        m_last     = N - 1;
        m_mem_en   = 1'b0;
        m_mem_addr = '0;
        m_ack      = 1'b0;
    endtask

    function automatic logic [N*AW-1:0] rand_addrs();
        logic [N*AW-1:0] a;
        for (int i = 0; i < N; i++) begin
            a[i*AW +: AW] = AW'($urandom);
        end
        return a;
    endfunction

    task automatic tick(input logic rst_v, input logic [N-1:0] v, input logic p,
                        input logic [N*AW-1:0] a);
        int            g;
        int            idx;
        int            cnt_next;
        int            mode_next;
        logic          rsp_now;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_rsp;
        @(negedge clk);
        rst       = rst_v;
        req_valid = v;
        pause_req = p;
        req_addr  = a;
        #1;
        g = -1;
        if (rst_v && m_mode == MODE_RUN) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        rsp_now   = (q.size() > 0) && (q[0].due == cyc);
        exp_rsp   = rsp_now ? (N'(1) << q[0].idx) : '0;

        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("mem_en",    32'(mem_en),    32'(m_mem_en));
        check("mem_addr",  32'(mem_addr),  32'(m_mem_addr));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (rsp_now) check("rsp_data", 32'(rsp_data), 32'(mem_word(q[0].addr)));
        check("busy",      32'(busy),      32'(q.size() != 0));
        check("pause_ack", 32'(pause_ack), 32'(m_ack));

        if (!rst_v) begin
            model_reset();
        end else begin
            cnt_next = q.size() + ((g >= 0) ? 1 : 0) - (rsp_now ? 1 : 0);
            case (m_mode)
                MODE_RUN:   mode_next = p ? MODE_DRAIN : MODE_RUN;
                MODE_DRAIN: mode_next = !p ? MODE_RUN : ((cnt_next == 0) ? MODE_PAUSED : MODE_DRAIN);
                default:    mode_next = p ? MODE_PAUSED : MODE_RUN;
            endcase
            m_mode   = mode_next;
            m_ack    = (mode_next == MODE_PAUSED);
            m_mem_en = (g >= 0);
            if (g >= 0) m_mem_addr = a[g*AW +: AW];
            if (rsp_now) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{due: cyc + 1 + L, idx: g, addr: a[g*AW +: AW]});
                m_last = g;
            end
        end
        cyc++;
    endtask

    logic [N*AW-1:0] fixed_a;
    logic            pz;

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst       = 1'b0;
        req_valid = '0;
        pause_req = 1'b0;
        req_addr  = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset hold with everyone requesting.
        repeat (3) tick(1'b0, 4'hF, 1'b0, rand_addrs());
        // Full contention, then let responses drain.
        repeat (14) tick(1'b1, 4'hF, 1'b0, rand_addrs());
        repeat (4) tick(1'b1, 4'h0, 1'b0, rand_addrs());
        // Requesters 1 and 3 only; top address must survive.
        fixed_a = '0;
        fixed_a[1*AW +: AW] = 17'h00010;
        fixed_a[3*AW +: AW] = 17'h1FFFF;
        repeat (10) tick(1'b1, 4'b1010, 1'b0, fixed_a);
        repeat (4) tick(1'b1, 4'h0, 1'b0, fixed_a);
        // Pause with reads in flight, hold until paused, then resume.
        repeat (3) tick(1'b1, 4'hF, 1'b0, rand_addrs());
        repeat (8) tick(1'b1, 4'hF, 1'b1, rand_addrs());
        repeat (6) tick(1'b1, 4'hF, 1'b0, rand_addrs());
        // Short pause pulse that abandons the drain.
        tick(1'b1, 4'hF, 1'b1, rand_addrs());
        tick(1'b1, 4'hF, 1'b0, rand_addrs());
        repeat (6) tick(1'b1, 4'h5, 1'b0, rand_addrs());
        repeat (4) tick(1'b1, 4'h0, 1'b0, rand_addrs());
        // Reset right after two transfers.
        repeat (2) tick(1'b1, 4'b0011, 1'b0, rand_addrs());
        tick(1'b0, 4'b0011, 1'b0, rand_addrs());
        repeat (6) tick(1'b1, 4'h0, 1'b0, rand_addrs());
        // Random traffic with pause bursts and occasional resets.
        pz = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 11) == 0) pz = ~pz;
            tick(($urandom_range(0, 79) != 0), N'($urandom), pz, rand_addrs());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
